// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for a common-anode/cathode 7-segment
//   display of NUM_DIGITS digits. Each digit gets a slot of SCAN_DIV clocks.
//   Within a slot the anode is lit for a brightness-controlled window that
//   always skips slot cycle 0, which acts as a ghosting guard. Digit content
//   comes from shadow registers loaded by a one-cycle strobe. Optional
//   leading-zero suppression blanks zero digits above the first significant
//   digit.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   load         in   strobe: capture hex/dp/blank into shadow registers
//   hex          in   4*NUM_DIGITS nibbles, digit 0 = bits [3:0]
//   dp           in   NUM_DIGITS decimal-point requests (1 = lit)
//   blank        in   NUM_DIGITS blank requests (1 = dark)
//   lz_suppress  in   live leading-zero suppression enable
//   brightness   in   live duty level 0..15
//   an           out  digit enables (polarity by AN_ACTIVE_LOW)
//   seg          out  segments bit0=a .. bit6=g (polarity by SEG_ACTIVE_LOW)
//   dp_out       out  decimal point (polarity by SEG_ACTIVE_LOW)
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 256,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_suppress,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_out
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DW-1:0]         LAST_DIGIT = DW'(NUM_DIGITS - 1);
    // Idle (off) levels of each output, folded in by XOR with the active-high value.
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [6:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF     = (SEG_ACTIVE_LOW != 0);

    // Active-high segment pattern, bit order g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    logic [SW-1:0]           slot_q, slot_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] hex_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dpo_q, dpo_d;

    logic [NUM_DIGITS-1:0]   lz_dark;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [3:0]              cur_nib;
    logic                    zero_run;
    logic                    lit;

    // Slot counter wraps naturally (SCAN_DIV is a power of two); the digit
    // index steps on the last cycle of each slot.
    always_comb begin
        slot_d  = slot_q + SW'(1);
        digit_d = digit_q;
        if (slot_q == '1) begin
            digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + DW'(1);
        end
    end

    always_comb begin
        // Walk down from the most significant digit; a digit is a leading
        // zero while every nibble at or above it is zero with no dp set.
        lz_dark  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (hex_q[4*k +: 4] == 4'h0) & ~dp_q[k];
            lz_dark[k] = zero_run;
        end

        cur_nib = hex_q[{digit_q, 2'b00} +: 4];
        onehot  = '0;
        onehot[digit_q] = 1'b1;

        lit = (slot_q != '0)
           && (slot_q[SW-1 -: 4] <= brightness)
           && !blank_q[digit_q]
           && !(lz_suppress && lz_dark[digit_q]);

        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dpo_d = DP_OFF;
        if (lit) begin
            an_d  = onehot ^ AN_OFF;
            seg_d = hex_to_seg(cur_nib) ^ SEG_OFF;
            dpo_d = dp_q[digit_q] ^ DP_OFF;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q  <= '0;
            digit_q <= '0;
            hex_q   <= '0;
            dp_q    <= '0;
            blank_q <= '1;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dpo_q   <= DP_OFF;
        end else begin
            slot_q  <= slot_d;
            digit_q <= digit_d;
            if (load) begin
                hex_q   <= hex;
                dp_q    <= dp;
                blank_q <= blank;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dpo_q <= dpo_d;
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign dp_out = dpo_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl. Instance "dut" uses the default
//   parameters (4 digits, 256-cycle slots, active-low outputs); instance "dut8"
//   uses 8 digits, 16-cycle slots and active-high outputs. Both share clock and
//   reset. Variable n counts clock edges since reset release; after edge n the
//   registered outputs reflect slot n % SCAN_DIV of digit (n / SCAN_DIV) % N.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load, lz_suppress;
    logic [15:0] hex;
    logic [3:0]  dp, blank, brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_out;

    logic        load8;
    logic [31:0] hex8;
    logic [7:0]  dp8, blank8;
    logic [7:0]  an8;
    logic [6:0]  seg8;
    logic        dp_out8;

    int tests = 0;
    int fails = 0;
    int n     = -1;

    always #5 clk = ~clk;

    seg_scan_ctrl dut (
        .clk(clk), .reset_n(reset_n), .load(load), .hex(hex), .dp(dp),
        .blank(blank), .lz_suppress(lz_suppress), .brightness(brightness),
        .an(an), .seg(seg), .dp_out(dp_out)
    );

    seg_scan_ctrl #(
        .NUM_DIGITS(8), .SCAN_DIV(16), .AN_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .load(load8), .hex(hex8), .dp(dp8),
        .blank(blank8), .lz_suppress(1'b0), .brightness(4'hF),
        .an(an8), .seg(seg8), .dp_out(dp_out8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                        input logic e_dp);
        chk({tag, ".an"},  32'(an),     32'(e_an));
        chk({tag, ".seg"}, 32'(seg),    32'(e_seg));
        chk({tag, ".dp"},  32'(dp_out), 32'(e_dp));
    endtask

    task automatic chk8(input string tag, input logic [7:0] e_an, input logic [6:0] e_seg,
                        input logic e_dp);
        chk({tag, ".an8"},  32'(an8),     32'(e_an));
        chk({tag, ".seg8"}, 32'(seg8),    32'(e_seg));
        chk({tag, ".dp8"},  32'(dp_out8), 32'(e_dp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic go_to(input int t);
        while (n < t) step();
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; lz_suppress = 1'b0; brightness = 4'hF;
        hex = 16'h0; dp = 4'h0; blank = 4'h0;
        load8 = 1'b0; hex8 = 32'h0; dp8 = 8'h0; blank8 = 8'h0;

        // Reset held: everything dark.
        step(); step();
        chk4("rst", 4'hF, 7'h7F, 1'b1);
        chk8("rst", 8'h00, 7'h00, 1'b0);

        // Release, then load both displays on the first edge (n=0).
        reset_n = 1'b1; n = -1;
        load = 1'b1; hex = 16'h12AF; dp = 4'h0; blank = 4'h0;
        load8 = 1'b1; hex8 = 32'h7654_3210;
        step();
        load = 1'b0; load8 = 1'b0;
        chk4("n0_guard", 4'hF, 7'h7F, 1'b1);
        chk8("n0_guard", 8'h00, 7'h00, 1'b0);

        go_to(1);
        chk4("d0_F", 4'hE, 7'h0E, 1'b1);
        chk8("d0_0", 8'h01, 7'h3F, 1'b0);
        go_to(15);   chk8("d0_last", 8'h01, 7'h3F, 1'b0);
        go_to(16);   chk8("d1_guard", 8'h00, 7'h00, 1'b0);
        go_to(17);   chk8("d1_1", 8'h02, 7'h06, 1'b0);
        go_to(113);  chk8("d7_7", 8'h80, 7'h07, 1'b0);
        go_to(129);  chk8("wrap_d0", 8'h01, 7'h3F, 1'b0);

        go_to(255);  chk4("d0_last", 4'hE, 7'h0E, 1'b1);
        go_to(256);  chk4("d1_guard", 4'hF, 7'h7F, 1'b1);
        go_to(257);  chk4("d1_A", 4'hD, 7'h08, 1'b1);
        go_to(513);  chk4("d2_2", 4'hB, 7'h24, 1'b1);
        go_to(769);  chk4("d3_1", 4'h7, 7'h79, 1'b1);
        go_to(1025); chk4("wrap_d0", 4'hE, 7'h0E, 1'b1);

        // Brightness 0: lit only for slot cycles 1..15.
        go_to(1280); brightness = 4'h0;
        go_to(1281); chk4("br0_first", 4'hD, 7'h08, 1'b1);
        go_to(1295); chk4("br0_last", 4'hD, 7'h08, 1'b1);
        go_to(1296); chk4("br0_off", 4'hF, 7'h7F, 1'b1);
        brightness = 4'h7;
        go_to(1297); chk4("br7_on", 4'hD, 7'h08, 1'b1);
        go_to(1407); chk4("br7_last", 4'hD, 7'h08, 1'b1);
        go_to(1408); chk4("br7_off", 4'hF, 7'h7F, 1'b1);
        brightness = 4'hF;

        // Leading-zero suppression with hex 0005.
        go_to(1535);
        load = 1'b1; hex = 16'h0005; dp = 4'h0; blank = 4'h0; lz_suppress = 1'b1;
        go_to(1536); load = 1'b0;
        go_to(1537); chk4("lz_d2_dark", 4'hF, 7'h7F, 1'b1);
        go_to(1793); chk4("lz_d3_dark", 4'hF, 7'h7F, 1'b1);
        go_to(2049); chk4("lz_d0_5", 4'hE, 7'h12, 1'b1);
        go_to(2305); chk4("lz_d1_dark", 4'hF, 7'h7F, 1'b1);
        lz_suppress = 1'b0;
        go_to(2306); chk4("nolz_d1_0", 4'hD, 7'h40, 1'b1);
        lz_suppress = 1'b1; load = 1'b1; dp = 4'b0100;
        go_to(2307); chk4("lz_live", 4'hF, 7'h7F, 1'b1);
        load = 1'b0;
        go_to(2308); chk4("lzdp_d1_0", 4'hD, 7'h40, 1'b1);
        go_to(2561); chk4("lzdp_d2_0dp", 4'hB, 7'h40, 1'b0);
        go_to(2817); chk4("lzdp_d3_dark", 4'hF, 7'h7F, 1'b1);
        go_to(3073); chk4("lzdp_d0_5", 4'hE, 7'h12, 1'b1);

        // Blank digit 1 with all decimal points requested.
        load = 1'b1; hex = 16'h12AF; dp = 4'hF; blank = 4'b0010; lz_suppress = 1'b0;
        go_to(3074); load = 1'b0;
        go_to(3075); chk4("blk_d0_dp", 4'hE, 7'h0E, 1'b0);
        go_to(3329); chk4("blk_d1_dark", 4'hF, 7'h7F, 1'b1);
        go_to(3585); chk4("blk_d2_dp", 4'hB, 7'h24, 1'b0);

        // Asynchronous reset mid-slot on digit 2.
        go_to(3600); chk4("pre_rst", 4'hB, 7'h24, 1'b0);
        reset_n = 1'b0;
        #1;
        chk4("async_rst", 4'hF, 7'h7F, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1; n = -1;
        go_to(5);  chk4("post_rst_noload", 4'hF, 7'h7F, 1'b1);
        go_to(20);
        load = 1'b1; hex = 16'h12AF; dp = 4'h0; blank = 4'h0;
        go_to(21); load = 1'b0;
        chk4("post_rst_capture", 4'hF, 7'h7F, 1'b1);
        go_to(22);  chk4("post_rst_d0", 4'hE, 7'h0E, 1'b1);
        go_to(257); chk4("post_rst_d1", 4'hD, 7'h08, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
